maj7_tt_scanner: RTL and testbench
==================================

MAJ7_TT_SCANNER -- requirements
Module: maj7_tt_scanner

Interface
REQ-001 Parameter N_IN, default 7: number of function inputs; truth-table width TT_W = 2**N_IN.
REQ-002 Parameter SETTLE, default 0: extra wait cycles per input vector before sampling f_in; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a full scan.
REQ-006 x_out  output  N_IN  input vector driven to the external combinational function under evaluation.
REQ-007 f_in  input  1  function output for the current x_out.
REQ-008 busy  output  1  high from the scan's first vector through its DONE cycle.
REQ-009 done  output  1  one-cycle pulse when tt is complete.
REQ-010 tt  output  TT_W  captured truth table; tt[i] = f(x = i), with x0 = i[0].
REQ-011 ones  output  N_IN+1  population count of tt.
REQ-012 exp_tt  input  TT_W  expected truth table (used only with TT_COMPARE_EN).
REQ-013 match  output  1  tt equals exp_tt (only with TT_COMPARE_EN).

Function
REQ-014 FSM states: IDLE, SETTLE_WAIT, SAMPLE, DONE.
REQ-015 IDLE: x_out = 0 and busy = 0; start = 1 clears tt and ones, sets idx = 0, and moves to SETTLE_WAIT if SETTLE > 0, else to SAMPLE.
REQ-016 x_out equals the registered idx at all times.
REQ-017 SETTLE_WAIT: counts SETTLE cycles with x_out stable, then moves to SAMPLE.
REQ-018 SAMPLE: tt[idx] <= f_in and ones <= ones + f_in.
REQ-019 SAMPLE, idx = TT_W-1: go to DONE.
REQ-020 SAMPLE, other idx: increment idx and return to SETTLE_WAIT or SAMPLE.
REQ-021 Scan length: exactly TT_W*(SETTLE+1) cycles from start acceptance to the DONE state.
REQ-022 DONE: done = 1 for one cycle, then IDLE; tt and ones hold until the next accepted start.
REQ-023 start outside IDLE is ignored; a start in the DONE cycle is ignored, so no back-to-back restart.
REQ-024 idx does not wrap; tt bits are written only while in SAMPLE.
REQ-025 ones = TT_W is representable (width N_IN+1); with all-ones f_in, ones = 128 for N_IN = 7.
REQ-026 Hex rendering convention: tt[TT_W-1] is the most significant digit.

Reset
REQ-027 rst asserted, at any time including mid-scan: state = IDLE, idx = 0, x_out = 0, tt = 0, ones = 0, busy = 0, done = 0, match = 0.
REQ-028 After rst deasserts, the block stays in IDLE until a new start.

Configuration
REQ-029 Macro TT_COMPARE_EN defined: match is registered in the DONE cycle as (tt_final == exp_tt), where tt_final includes the last sampled bit, and holds until the next start or rst; match is cleared when a start is accepted.
REQ-030 TT_COMPARE_EN undefined: exp_tt is unused and match is tied to 0; no comparator logic is present.

Structure
REQ-031 Shared package maj7_tt_pkg holds the FSM state enum, N_IN_DEFAULT = 7, and the TT_W derivation function.
REQ-032 One sub-module, maj7_tt_popcnt_acc: the ones accumulator with synchronous clear and increment enable.
REQ-033 The function under evaluation is external to this block and connects only through x_out and f_in.

Verification
REQ-034 f_in = x_out[0], SETTLE = 0, one start pulse -> done exactly 128 cycles later; tt = 0xAAAA…AAAA (32 hex digits); ones = 64.
REQ-035 f_in tied to 1 -> tt = all ones, ones = 128; f_in tied to 0 -> tt = 0, ones = 0.
REQ-036 f_in = majority(x0, x1, x4) -> tt matches the software model bit-for-bit; ones = 64.
REQ-037 SETTLE = 3 -> done 512 cycles after start; x_out is stable across each 4-cycle window.
REQ-038 start re-pulsed at vector 40 -> ignored, scan completes normally; rst at vector 40 -> all outputs 0 and IDLE next cycle.
REQ-039 TT_COMPARE_EN defined, exp_tt = 0xAAAA…AAAA with f_in = x0 -> match = 1; the same run with bit 5 of exp_tt flipped -> match = 0.

Source files
------------

// File: rtl/maj7_tt_pkg.sv
// Shared types and helpers for the truth-table scanner.
package maj7_tt_pkg;

    localparam int unsigned N_IN_DEFAULT = 7;
    localparam int unsigned SETTLE_CNT_W = 4;

    // Scanner FSM states
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SETTLE_WAIT = 2'd1,
        ST_SAMPLE      = 2'd2,
        ST_DONE        = 2'd3
    } scan_state_e;

    // Truth-table width for an n-input function
    function automatic int unsigned tt_w(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/maj7_tt_popcnt_acc.sv
// Running count of sampled ones: synchronous clear, increment by one when enabled.
module maj7_tt_popcnt_acc #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Accumulator register; clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/maj7_tt_scanner.sv
// Walks every input vector of an external combinational function, captures
// its truth table and the number of true entries.
// Optional: define TT_COMPARE_EN to compare the finished table with exp_tt.
module maj7_tt_scanner
    import maj7_tt_pkg::*;
#(
    parameter  int unsigned N_IN   = N_IN_DEFAULT,
    parameter  int unsigned SETTLE = 0,
    localparam int unsigned TT_W   = tt_w(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] x_out,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic [N_IN:0]   ones,
    input  logic [TT_W-1:0] exp_tt,
    output logic            match
);

    localparam logic [N_IN-1:0]         IDX_LAST    = '1;
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
        (SETTLE == 0) ? '0 : SETTLE_CNT_W'(SETTLE - 1);
    // Every vector starts in SETTLE_WAIT unless no settling is requested
    localparam scan_state_e VEC_FIRST = (SETTLE > 0) ? ST_SETTLE_WAIT : ST_SAMPLE;

    scan_state_e             state, state_next;
    logic [N_IN-1:0]         idx, idx_next;
    logic [TT_W-1:0]         tt_next;
    logic [SETTLE_CNT_W-1:0] settle_cnt, settle_next;
    logic                    busy_next, done_next;
    logic                    acc_clr, acc_inc;
`ifdef TT_COMPARE_EN
    logic                    match_next;
`endif

    assign x_out = idx;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            tt         <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            tt         <= tt_next;
            settle_cnt <= settle_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    // Next-state, datapath updates and registered-output next values
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        tt_next     = tt;
        settle_next = settle_cnt;
        acc_clr     = 1'b0;
        acc_inc     = 1'b0;
`ifdef TT_COMPARE_EN
        match_next  = match;
`endif
        case (state)
            ST_IDLE: begin
                idx_next = '0;
                if (start) begin
                    tt_next     = '0;
                    acc_clr     = 1'b1;
                    settle_next = '0;
                    state_next  = VEC_FIRST;
`ifdef TT_COMPARE_EN
                    match_next  = 1'b0;
`endif
                end
            end
            ST_SETTLE_WAIT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_next = '0;
                    state_next  = ST_SAMPLE;
                end else begin
                    settle_next = settle_cnt + SETTLE_CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                tt_next[idx] = f_in;
                acc_inc      = f_in;
                if (idx == IDX_LAST) begin
                    state_next = ST_DONE;
`ifdef TT_COMPARE_EN
                    // Compare against the table including the bit sampled now
                    match_next = (tt_next == exp_tt);
`endif
                end else begin
                    idx_next   = idx + N_IN'(1);
                    state_next = VEC_FIRST;
                end
            end
            ST_DONE: begin
                idx_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                idx_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

`ifdef TT_COMPARE_EN
    // Comparison result, captured on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match <= 1'b0;
        end else begin
            match <= match_next;
        end
    end
`else
    logic unused_exp_tt;
    assign unused_exp_tt = ^exp_tt;
    assign match         = 1'b0;
`endif

    maj7_tt_popcnt_acc #(
        .W (N_IN + 1)
    ) u_popcnt_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .inc   (acc_inc),
        .count (ones)
    );

endmodule

// File: tb/tb_maj7_tt_scanner.sv
// Scoreboard bench for maj7_tt_scanner: two instances (SETTLE 0 and 3) scanning
// reference functions defined in the bench.
module tb_maj7_tt_scanner;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   ones;
        int           done_cyc;
        logic         match;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0 = 1'b0, start3 = 1'b0;
    logic [6:0]   x0, x3;
    logic         f0, f3;
    logic         busy0, busy3, done0, done3, match0, match3;
    logic [127:0] tt0, tt3;
    logic [7:0]   ones0, ones3;
    logic [127:0] exp_tt = '0;
    logic [127:0] lut = '0;
    int           mode = 0;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    exp_t         q0[$];
    exp_t         q3[$];
    logic         prev_done0 = 1'b0, prev_done3 = 1'b0;
    logic [6:0]   last3 = '0;
    int           run3 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference functions: 0 x0, 1 const 1, 2 const 0, 3 maj(x0,x1,x4), 4 random table
    function automatic logic f_model(input int m, input logic [6:0] x);
        case (m)
            0: return x[0];
            1: return 1'b1;
            2: return 1'b0;
            3: return (int'(x[0]) + int'(x[1]) + int'(x[4])) >= 2;
            default: return lut[x];
        endcase
    endfunction

    assign f0 = f_model(mode, x0);
    assign f3 = f_model(mode, x3);

    maj7_tt_scanner #(.N_IN(7), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .x_out(x0), .f_in(f0),
        .busy(busy0), .done(done0), .tt(tt0), .ones(ones0),
        .exp_tt(exp_tt), .match(match0)
    );

    maj7_tt_scanner #(.N_IN(7), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .x_out(x3), .f_in(f3),
        .busy(busy3), .done(done3), .tt(tt3), .ones(ones3),
        .exp_tt(exp_tt), .match(match3)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the SETTLE=0 instance
    always @(negedge clk) begin
        if (rst) begin
            prev_done0 <= 1'b0;
        end else begin
            if (prev_done0) begin
                check("dut0_done_one_cycle", done0, 0);
                check("dut0_busy_after_done", busy0, 0);
                check("dut0_x_idle", x0, 0);
            end
            prev_done0 <= done0;
            if (done0) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut0_unexpected_done actual=done required=no_done (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("dut0_tt", tt0, e.tt);
                    check("dut0_ones", ones0, e.ones);
                    check("dut0_latency", cyc, e.done_cyc);
                    check("dut0_busy_in_done", busy0, 1);
                    check("dut0_match", match0, e.match);
                end
            end
        end
    end

    // Monitor for the SETTLE=3 instance, including x_out hold time per vector
    always @(negedge clk) begin
        if (rst) begin
            prev_done3 <= 1'b0;
            run3       <= 0;
            last3      <= '0;
        end else begin
            if (x3 != last3) begin
                if (last3 != 0 && x3 != 0) begin
                    check("dut3_x_hold", run3, 4);
                    check("dut3_x_step", x3, last3 + 7'd1);
                end
                run3 <= 1;
            end else begin
                run3 <= run3 + 1;
            end
            last3 <= x3;
            if (prev_done3) begin
                check("dut3_done_one_cycle", done3, 0);
                check("dut3_busy_after_done", busy3, 0);
            end
            prev_done3 <= done3;
            if (done3) begin
                if (q3.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut3_unexpected_done actual=done required=no_done (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q3.pop_front();
                    check("dut3_tt", tt3, e.tt);
                    check("dut3_ones", ones3, e.ones);
                    check("dut3_latency", cyc, e.done_cyc);
                    check("dut3_match", match3, e.match);
                end
            end
        end
    end

    // Build expected result, push it, and pulse start on the chosen instance
    task automatic issue_scan(input int d, input int m, input bit flip);
        exp_t         e;
        logic [127:0] t;
        mode = m;
        if (m == 4) lut = {$urandom, $urandom, $urandom, $urandom};
        case (m)
            0: begin t = {32{4'hA}}; e.ones = 8'd64;  end
            1: begin t = '1;          e.ones = 8'd128; end
            2: begin t = '0;          e.ones = 8'd0;   end
            default: begin
                t = '0;
                for (int i = 0; i < 128; i++) t[i] = f_model(m, 7'(i));
                e.ones = (m == 3) ? 8'd64 : 8'($countones(t));
            end
        endcase
        exp_tt = flip ? (t ^ (128'(1) << 5)) : t;
        e.tt   = t;
`ifdef TT_COMPARE_EN
        e.match = !flip;
`else
        e.match = 1'b0;
`endif
        e.done_cyc = cyc + 1 + ((d == 0) ? 128 : 512);
        if (d == 0) begin q0.push_back(e); start0 = 1'b1; end
        else        begin q3.push_back(e); start3 = 1'b1; end
        tick();
        start0 = 1'b0;
        start3 = 1'b0;
    endtask

    // Wait for all outstanding results of one instance, bounded
    task automatic drain(input int d);
        for (int k = 0; k < 1200; k++) begin
            if (((d == 0) ? q0.size() : q3.size()) == 0) break;
            tick();
        end
        if (((d == 0) ? q0.size() : q3.size()) != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout dut%0d actual=pending required=empty", (d == 0) ? 0 : 3);
        end
        tick();
        tick();
    endtask

    task automatic wait_x0(input logic [6:0] v);
        for (int k = 0; k < 300 && x0 != v; k++) tick();
        check("wait_x0_reached", x0, v);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_x_out", x0, 0);
        check("rst_tt", tt0, 0);
        check("rst_ones", ones0, 0);
        check("rst_busy_done", {busy0, done0, match0, busy3, done3}, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_after_rst", busy0, 0);

        // Directed functions on the SETTLE=0 instance
        issue_scan(0, 0, 1'b0); drain(0);
        issue_scan(0, 1, 1'b0); drain(0);
        issue_scan(0, 2, 1'b0); drain(0);
        issue_scan(0, 3, 1'b0); drain(0);
        issue_scan(0, 0, 1'b1); drain(0);

        // SETTLE=3 instance: x0 function and random table
        issue_scan(1, 0, 1'b0); drain(1);
        issue_scan(1, 4, 1'b0); drain(1);

        // Start mid-scan is ignored
        issue_scan(0, 4, 1'b0);
        wait_x0(7'd40);
        start0 = 1'b1; tick(); start0 = 1'b0;
        drain(0);

        // Start during the DONE cycle is ignored
        issue_scan(0, 3, 1'b0);
        for (int k = 0; k < 300 && !done0; k++) tick();
        check("done_seen", done0, 1);
        start0 = 1'b1; tick(); start0 = 1'b0;
        repeat (20) tick();
        check("no_restart_from_done", busy0, 0);
        check("no_restart_x", x0, 0);

        // Reset at vector 40
        issue_scan(0, 1, 1'b0);
        wait_x0(7'd40);
        #2 rst = 1'b1;
        #1;
        check("midrst_x_out", x0, 0);
        check("midrst_tt", tt0, 0);
        check("midrst_ones", ones0, 0);
        check("midrst_flags", {busy0, done0, match0}, 0);
        q0.delete();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("midrst_stays_idle", {busy0, x0}, 0);

        // Randomized scans after reset recovery
        for (int n = 0; n < 6; n++) begin
            int d;
            d = (n % 3 == 2) ? 1 : 0;
            issue_scan(d, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            drain(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
